// File: rtl/jpeg_pkg.sv
// Shared JPEG decode constants: coefficient/quant widths, zigzag-to-natural map
// and the dequantizer FSM state type.
package jpeg_pkg;

  localparam int COEF_W = 12;
  localparam int QV_W   = 8;
  localparam int PROD_W = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } dz_state_t;

  // Element 0 is the leftmost entry: ZZ2NAT[zigzag_idx] = row*8 + col.
  localparam logic [0:63][5:0] ZZ2NAT = {
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/dequant_sat.sv
// Combinational coefficient x quant-value multiply, saturated back to the
// signed coefficient range.
module dequant_sat
  import jpeg_pkg::*;
(
  input  logic signed [COEF_W-1:0] i_coef,
  input  logic        [QV_W-1:0]   i_qv,
  output logic signed [COEF_W-1:0] o_sat
);

  localparam logic signed [PROD_W-1:0] SAT_MAX = 20'sd2047;
  localparam logic signed [PROD_W-1:0] SAT_MIN = -20'sd2048;

  logic signed [PROD_W-1:0] w_prod;

  // 12b signed x 8b unsigned always fits in 20b signed.
  assign w_prod = PROD_W'(i_coef) * $signed({{(PROD_W-QV_W){1'b0}}, i_qv});

  always_comb begin
    o_sat = w_prod[COEF_W-1:0];
    if (w_prod > SAT_MAX)      o_sat = SAT_MAX[COEF_W-1:0];
    else if (w_prod < SAT_MIN) o_sat = SAT_MIN[COEF_W-1:0];
  end

endmodule

// File: rtl/dequant_zigzag.sv
// Collects zigzag-ordered coefficients of one 8x8 block, dequantizes them with
// a per-channel table and presents the natural-order block for the IDCT.
//
//   state | meaning
//   IDLE  | waiting for the first coefficient of a block
//   FILL  | accepting coefficients 1..63 (or until eob)
//   EMIT  | valid_out pulse cycle, coefficient input stalled
`ifndef CH
`define CH 3
`endif

module dequant_zigzag
  import jpeg_pkg::*;
#(
  parameter int CH = `CH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            qt_wr_en,
  input  logic [$clog2(CH+1)-1:0]         qt_wr_sel,
  input  logic [5:0]                      qt_wr_idx,
  input  logic [QV_W-1:0]                 qt_wr_data,
  input  logic                            coef_valid,
  output logic                            coef_ready,
  input  logic signed [COEF_W-1:0]        coef_in,
  input  logic                            coef_eob,
  input  logic [$clog2(CH+1)-1:0]         coef_channel,
  output logic signed [7:0][7:0][COEF_W-1:0] block_out,
  output logic [$clog2(CH+1)-1:0]         channel_out,
  output logic                            valid_out
);

  localparam int SW = $clog2(CH+1);

  dz_state_t r_state, w_state_nxt;
  logic [5:0]                    r_idx;
  logic [SW-1:0]                 r_chan;
  logic [63:0]                   r_mask;
  logic [63:0][COEF_W-1:0]       r_buf;
  logic [CH-1:0][63:0][QV_W-1:0] r_qt;
  logic [63:0][COEF_W-1:0]       r_block;
  logic [SW-1:0]                 r_chan_out;
  logic                          r_valid;

  logic                    w_acc;
  logic                    w_done;
  logic [SW-1:0]           w_chan;
  logic [QV_W-1:0]         w_qv;
  logic [5:0]              w_pos;
  logic signed [COEF_W-1:0] w_sat;
  logic [63:0]             w_mask_nxt;
  logic [63:0][COEF_W-1:0] w_block_nxt;

  assign coef_ready  = (r_state != EMIT);
  assign w_acc       = coef_valid & coef_ready;
  assign w_done      = w_acc & ((r_idx == 6'd63) | coef_eob);
  assign w_chan      = (r_state == IDLE) ? coef_channel : r_chan;
  assign w_pos       = ZZ2NAT[r_idx];
  assign w_mask_nxt  = ((r_state == IDLE) ? 64'd0 : r_mask) | (w_acc ? (64'd1 << w_pos) : 64'd0);

  // Channel select by loop so an out-of-range channel reads 0 instead of indexing past the table.
  always_comb begin
    w_qv = '0;
    for (int c = 0; c < CH; c++) begin
      if (w_chan == SW'(c)) w_qv = r_qt[c][r_idx];
    end
  end

  dequant_sat u_sat (
    .i_coef (coef_in),
    .i_qv   (w_qv),
    .o_sat  (w_sat)
  );

  // Output block merges the coefficient accepted on the completing edge.
  always_comb begin
    w_block_nxt = '0;
    for (int p = 0; p < 64; p++) begin
      if (w_mask_nxt[p]) w_block_nxt[p] = (p == int'(w_pos)) ? w_sat : r_buf[p];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_state_nxt = w_done ? EMIT : FILL;
      FILL:    if (w_done) w_state_nxt = EMIT;
      EMIT:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_chan     <= '0;
      r_mask     <= '0;
      r_block    <= '0;
      r_chan_out <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_done;
      if (w_acc) r_mask <= w_mask_nxt;
      if ((r_state == IDLE) && w_acc) r_chan <= coef_channel;
      if (w_done)                r_idx <= '0;
      else if (w_acc)            r_idx <= r_idx + 6'd1;
      else if (r_state != FILL)  r_idx <= '0;
      if (w_done) begin
        r_block    <= w_block_nxt;
        r_chan_out <= w_chan;
      end
    end
  end

  // Stale entries are hidden by the mask, so the buffer needs no reset.
  always_ff @(posedge clk) begin
    if (w_acc) r_buf[w_pos] <= w_sat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        for (int i = 0; i < 64; i++) r_qt[c][i] <= 8'd1;
      end
    end else if (qt_wr_en) begin
      for (int c = 0; c < CH; c++) begin
        if (qt_wr_sel == SW'(c)) r_qt[c][qt_wr_idx] <= qt_wr_data;
      end
    end
  end

  assign block_out   = r_block;
  assign channel_out = r_chan_out;
  assign valid_out   = r_valid;

endmodule

// File: tb/tb_dequant_zigzag.sv
// Scoreboard bench for dequant_zigzag: driver pushes expected natural-order
// blocks, a negedge monitor pops and compares on every valid_out pulse.
`timescale 1ns/1ps
module tb_dequant_zigzag;
  localparam int CH = 3;
  localparam int SW = $clog2(CH+1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic qt_wr_en = 1'b0;
  logic [SW-1:0] qt_wr_sel = '0;
  logic [5:0] qt_wr_idx = '0;
  logic [7:0] qt_wr_data = '0;
  logic coef_valid = 1'b0;
  logic coef_ready;
  logic signed [11:0] coef_in = '0;
  logic coef_eob = 1'b0;
  logic [SW-1:0] coef_channel = '0;
  logic signed [7:0][7:0][11:0] block_out;
  logic [SW-1:0] channel_out;
  logic valid_out;

  dequant_zigzag #(.CH(CH)) dut (
    .clk          (clk),
    .rst          (rst),
    .qt_wr_en     (qt_wr_en),
    .qt_wr_sel    (qt_wr_sel),
    .qt_wr_idx    (qt_wr_idx),
    .qt_wr_data   (qt_wr_data),
    .coef_valid   (coef_valid),
    .coef_ready   (coef_ready),
    .coef_in      (coef_in),
    .coef_eob     (coef_eob),
    .coef_channel (coef_channel),
    .block_out    (block_out),
    .channel_out  (channel_out),
    .valid_out    (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0][11:0] v;
    logic [SW-1:0]     ch;
  } blk_t;

  blk_t exp_q[$];
  int   pulse_cyc[$];
  int   zz[64];
  int   qt[CH][64];
  int   cbuf[64];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_pres = 0;
  int   n_pulses = 0;
  int   n_pushed = 0;

  blk_t mon_e;
  int   mon_nbad;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    if (x > 2047) return 2047;
    if (x < -2048) return -2048;
    return x;
  endfunction

  function automatic int bo(input int r, input int c);
    return int'($signed(block_out[r][c]));
  endfunction

  function automatic int nonzero_cnt();
    int n = 0;
    for (int p = 0; p < 64; p++) if (bo(p / 8, p % 8) != 0) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    if (rst && valid_out) begin
      n_pulses++;
      pulse_cyc.push_back(cyc);
      chk("ready_low_in_emit", int'(coef_ready), 0);
      chk("latency", cyc - last_pres, 1);
      chk("block_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_nbad = 0;
        for (int p = 0; p < 64; p++) begin
          if (bo(p / 8, p % 8) != int'($signed(mon_e.v[p]))) begin
            if (mon_nbad == 0)
              $display("  first bad position %0d: got %0d want %0d", p, bo(p / 8, p % 8),
                       int'($signed(mon_e.v[p])));
            mon_nbad++;
          end
        end
        chk("block_data_bad_entries", mon_nbad, 0);
        chk("channel_out", int'(channel_out), int'(mon_e.ch));
      end
    end
  end

  task automatic qt_write(input int sel, input int idx, input int val);
    qt_wr_en = 1'b1; qt_wr_sel = SW'(sel); qt_wr_idx = 6'(idx); qt_wr_data = 8'(val);
    @(posedge clk); #1;
    qt_wr_en = 1'b0;
    qt[sel][idx] = val;
  endtask

  task automatic send_block(input int ch, input int n, input bit eob, input bit push,
                            input bit hold, input bit gaps, input int wr_at, input int wr_val);
    blk_t e;
    int t;
    e = '0;
    e.ch = SW'(ch);
    for (int i = 0; i < n; i++) e.v[zz[i]] = 12'(sat(cbuf[i] * qt[ch][i]));
    if (push) begin exp_q.push_back(e); n_pushed++; end
    for (int i = 0; i < n; i++) begin
      coef_valid = 1'b1;
      coef_in = 12'(cbuf[i]);
      coef_eob = eob && (i == n - 1);
      coef_channel = (i == 0) ? SW'(ch) : SW'($urandom_range(0, CH - 1));
      if (i == wr_at) begin
        qt_wr_en = 1'b1; qt_wr_sel = SW'(ch); qt_wr_idx = 6'(i); qt_wr_data = 8'(wr_val);
      end
      t = 0;
      @(negedge clk);
      while (!coef_ready && t < 8) begin t++; @(negedge clk); end
      if (!coef_ready) chk("coef_ready_wait", int'(coef_ready), 1);
      last_pres = cyc;
      @(posedge clk); #1;
      qt_wr_en = 1'b0;
      if (i == wr_at) qt[ch][i] = wr_val;
      if (gaps && i < n - 1 && $urandom_range(0, 3) == 0) begin
        coef_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    coef_eob = 1'b0;
    if (!hold) coef_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 200) begin @(posedge clk); #1; t++; end
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic rand_coefs(input int lo, input int hi);
    for (int i = 0; i < 64; i++) cbuf[i] = int'($urandom_range(0, hi - lo)) + lo;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, ch, n, d;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 1) begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin zz[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin zz[k] = r * 8 + (s - r); k++; end
      end
    end
    for (int c = 0; c < CH; c++) for (int i = 0; i < 64; i++) qt[c][i] = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_out", int'(valid_out), 0);
    chk("reset_channel_out", int'(channel_out), 0);
    chk("reset_block_nonzero", nonzero_cnt(), 0);
    @(negedge clk); rst = 1'b1;
    #1 chk("ready_after_reset", int'(coef_ready), 1);
    @(posedge clk); #1;

    // all-5 block, identity tables
    for (int i = 0; i < 64; i++) cbuf[i] = 5;
    send_block(0, 64, 1'b0, 1'b1, 1'b0, 1'b0, -1, 0);
    drain();
    chk("all5_corner", bo(7, 7), 5);

    // DC-only block on channel 1 with table of 16s
    for (int i = 0; i < 64; i++) qt_write(1, i, 16);
    cbuf[0] = 100;
    send_block(1, 1, 1'b1, 1'b1, 1'b0, 1'b0, -1, 0);
    drain();
    chk("dc_value", bo(0, 0), 1600);
    chk("dc_channel", int'(channel_out), 1);
    chk("dc_nonzero", nonzero_cnt(), 1);

    qt_write(0, 1, 2);
    qt_write(0, 2, 1);
    cbuf[0] = 0; cbuf[1] = 3; cbuf[2] = -4;
    send_block(0, 3, 1'b1, 1'b1, 1'b0, 1'b0, -1, 0);
    drain();
    chk("zz1_value", bo(0, 1), 6);
    chk("zz2_value", bo(1, 0), -4);
    chk("zz_nonzero", nonzero_cnt(), 2);

    for (int i = 0; i < 3; i++) qt_write(2, i, 255);
    cbuf[0] = 2047; cbuf[1] = -2048; cbuf[2] = 9;
    send_block(2, 3, 1'b1, 1'b1, 1'b0, 1'b0, -1, 0);
    drain();
    chk("sat_pos", bo(0, 0), 2047);
    chk("sat_neg", bo(0, 1), -2048);
    chk("sat_small", bo(1, 0), 2047);

    // table write colliding with the coefficient that uses that entry
    rand_coefs(-200, 200);
    send_block(0, 64, 1'b0, 1'b1, 1'b0, 1'b1, 5, 77);
    for (int i = 0; i < 64; i++) cbuf[i] = 1;
    send_block(0, 10, 1'b1, 1'b1, 1'b0, 1'b0, -1, 0);
    drain();
    chk("new_table_value", bo(zz[5] / 8, zz[5] % 8), 77);

    repeat (8) begin
      repeat (5) qt_write($urandom_range(0, CH - 1), $urandom_range(0, 63), $urandom_range(0, 255));
      ch = $urandom_range(0, CH - 1);
      n = $urandom_range(1, 64);
      if ($urandom_range(0, 3) == 0) rand_coefs(-2048, 2047);
      else rand_coefs(-60, 60);
      send_block(ch, n, (n < 64) ? 1'b1 : 1'(($urandom_range(0, 1))), 1'b1, 1'b0, 1'b1, -1, 0);
    end
    drain();

    // back-to-back full blocks with valid held high
    rand_coefs(-100, 100);
    send_block(1, 64, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0);
    rand_coefs(-100, 100);
    send_block(2, 64, 1'b0, 1'b1, 1'b0, 1'b0, -1, 0);
    drain();
    d = (pulse_cyc.size() >= 2) ? pulse_cyc[pulse_cyc.size() - 1] - pulse_cyc[pulse_cyc.size() - 2] : -1;
    chk("stream_pulse_spacing", d, 65);

    // reset in the middle of a block
    for (int i = 0; i < 64; i++) cbuf[i] = 7;
    send_block(1, 30, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0);
    #2 rst = 1'b0;
    #1;
    chk("midfill_reset_valid", int'(valid_out), 0);
    chk("midfill_reset_block", nonzero_cnt(), 0);
    chk("midfill_reset_channel", int'(channel_out), 0);
    coef_valid = 1'b0;
    for (int c = 0; c < CH; c++) for (int i = 0; i < 64; i++) qt[c][i] = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1 chk("ready_after_midfill_reset", int'(coef_ready), 1);
    @(posedge clk); #1;
    d = n_pulses;
    send_block(1, 64, 1'b0, 1'b1, 1'b0, 1'b0, -1, 0);
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("pulses_after_reset", n_pulses - d, 1);
    chk("seven_value", bo(4, 3), 7);

    chk("pending_at_end", exp_q.size(), 0);
    chk("pulse_count", n_pulses, n_pushed);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dequant_zigzag.md
DEQUANT_ZIGZAG -- requirements
Module: dequant_zigzag

Interface
REQ-001 SHALL take parameter CH, default `CH from sys_defs.svh, the number of colour channels (quant tables).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port qt_wr_en  input  1  quant-table write strobe.
REQ-005 SHALL have port qt_wr_sel  input  $clog2(CH+1)  table (channel) being written.
REQ-006 SHALL have port qt_wr_idx  input  6  table entry, zigzag order.
REQ-007 SHALL have port qt_wr_data  input  8  unsigned quant value.
REQ-008 SHALL have port coef_valid  input  1  coefficient present.
REQ-009 SHALL have port coef_ready  output  1  coefficient accepted this cycle when valid and ready are both high.
REQ-010 SHALL have port coef_in  input  signed 12  Huffman-decoded coefficient, zigzag order.
REQ-011 SHALL have port coef_eob  input  1  marks the last coded coefficient of the block; the remaining positions are zero.
REQ-012 SHALL have port coef_channel  input  $clog2(CH+1)  channel of the block, sampled on its first coefficient.
REQ-013 SHALL have port block_out  output  signed 12 [7:0][7:0]  dequantized natural-order block, [row][col].
REQ-014 SHALL have port channel_out  output  $clog2(CH+1)  channel of block_out.
REQ-015 SHALL have port valid_out  output  1  one-cycle pulse per block; drives the 2D IDCT valid_in.

Function
REQ-016 SHALL use an FSM with states IDLE, FILL and EMIT.
- IDLE→FILL on the first accepted coefficient.
- FILL→EMIT on accepting zigzag index 63 or a coefficient with coef_eob=1.
- EMIT→IDLE unconditionally after 1 cycle.
REQ-017 SHALL drive coef_ready high in IDLE and FILL, and low in EMIT.
REQ-018 SHALL keep a 6-bit zigzag index: cleared in IDLE/EMIT, incremented per accepted coefficient, never wrapping past 63.
REQ-019 SHALL compute each accepted coefficient as coef_in × qt[channel][idx] into a 20-bit signed product, saturated to [-2048, 2047].
REQ-020 SHALL write the saturated value in the same cycle to natural position zz2nat[idx] and set that position's bit in a 64-bit written mask.
REQ-021 SHALL clear the written mask on entry to FILL; positions whose mask bit is clear SHALL read as 0 on block_out.
REQ-022 SHALL, in the EMIT cycle, pulse valid_out=1 and update block_out/channel_out; both SHALL hold until the next EMIT.
REQ-023 SHALL have a latency of 1 cycle from acceptance of the last coefficient to valid_out; peak throughput SHALL be 1 block per 65 cycles.
REQ-024 SHALL apply quant-table writes in any state; the write lands at the clock edge.
REQ-025 SHALL, when a coefficient is accepted in the same cycle as a write to the entry it uses, use the old table value.
REQ-026 SHALL latch coef_channel only on the first coefficient; channel changes mid-block are ignored.
REQ-027 SHALL sample coef_eob only when valid and ready are both high; coef_eob on index 63 is equivalent to a normal index-63 completion.

Reset
REQ-028 SHALL, on rst low, immediately force: state=IDLE, index=0, mask=0, valid_out=0, channel_out=0, block_out all 0.
REQ-029 SHALL reset all quant-table entries to 1 (identity dequant).
REQ-030 SHALL, on reset mid-FILL, discard the partial block; no valid_out pulse follows.
REQ-031 SHALL drive coef_ready high in the first cycle after rst deasserts.

Structure
REQ-032 SHALL import the zigzag-to-natural table (64×6-bit constant), the 12-bit coefficient width and the 8-bit quant-value width from a shared package, jpeg_pkg.
REQ-033 SHALL place the multiply-and-saturate in one combinational sub-module, dequant_sat, reusable by other stages.

Verification
REQ-034 Reset tables, feed 64 coefficients all =5 on channel 0 → valid_out pulses 1 cycle after the last one; every block_out entry = 5.
REQ-035 Load qt[1] all =16, feed DC=100 then coef_eob on coefficient 0 → block_out[0][0]=1600, all others 0, channel_out=1.
REQ-036 Load qt[0][1]=2, feed zigzag coefficients 0=0, 1=3, 2=-4 (eob) with qt[0][2]=1 → [0][1]=6, [1][0]=-4, rest 0.
REQ-037 Saturation: qt=255 with coef 2047 → 2047; coef -2048 → -2048; coef 9 → 2047.
REQ-038 Hold coef_valid high continuously for two blocks → coef_ready=0 exactly in the EMIT cycle; second block intact; pulses 65 cycles apart.
REQ-039 Assert rst at zigzag index 30, then feed a full block of 7s → exactly one valid_out, all entries 7.
